pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 64: data path width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low.
REQ-004 in_data  input  WIDTH  upstream payload from the select stage.
REQ-005 in_valid  input  1  upstream payload valid.
REQ-006 in_ready  output  1  block can accept payload; registered.
REQ-007 out_data  output  WIDTH  payload to downstream stage; registered.
REQ-008 out_valid  output  1  out_data valid; registered.
REQ-009 out_ready  input  1  downstream accepts out_data.
REQ-010 flush  input  1  discard all held entries; present only with PIPE_FLUSH_EN.

Function
REQ-011 Input transfer SHALL occur when in_valid & in_ready are both 1 at a rising edge.
- Output transfer SHALL occur when out_valid & out_ready are both 1 at a rising edge.
REQ-012 The block SHALL hold at most two entries: main register (drives out_data) and skid register.
REQ-013 The state machine SHALL have three states: EMPTY (0 entries), BUSY (main only), FULL (main + skid).
REQ-014 EMPTY: input transfer -> BUSY, main <= in_data; otherwise stay.
REQ-015 BUSY transitions SHALL be:
- input and output transfer -> BUSY, main <= in_data;
- input only -> FULL, skid <= in_data;
- output only -> EMPTY;
- neither -> stay.
REQ-016 FULL: output transfer -> BUSY, main <= skid; otherwise stay; in_data is ignored in FULL.
REQ-017 out_valid SHALL be 1 exactly in BUSY and FULL.
REQ-018 in_ready SHALL be registered and equal 1 exactly when the next state is not FULL, so in_ready is never combinationally dependent on out_ready.
REQ-019 Latency SHALL be 1 cycle from input transfer to out_valid in EMPTY.
- Sustained throughput SHALL be one transfer per cycle while out_ready stays 1.
REQ-020 Entries SHALL leave in arrival order; no payload is dropped or duplicated except by flush.
REQ-021 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 When out_valid=0, out_data SHALL retain its last value.

Reset
REQ-023 While reset=0 at a rising edge:
- state <= EMPTY, out_valid <= 0, in_ready <= 0;
- out_data <= 0, skid <= 0;
- in_valid and out_ready are ignored.
REQ-024 At the first rising edge with reset=1, in_ready SHALL become 1.
REQ-025 Reset asserted mid-operation SHALL discard held entries with no downstream transfer.

Configuration
REQ-026 Macro PIPE_FLUSH_EN, when defined, SHALL add the flush port.
- flush=1 at a rising edge -> state EMPTY, out_valid <= 0, in_ready <= 1.
- Data registers are unchanged.
- Any simultaneous input transfer is dropped; flush takes priority over every transition.
- Reset takes priority over flush.
REQ-027 Without PIPE_FLUSH_EN, the flush port and its logic SHALL be absent, and behaviour equals flush tied to 0.

Structure
REQ-028 Package pipe_pkg SHALL hold the default width constant PIPE_WIDTH=64 and the enum typedef pipe_state_t {EMPTY, BUSY, FULL}.
REQ-029 Sub-module pipe_skid_mux SHALL provide the WIDTH-wide main-register next-value select (in_data vs skid).
- It is built from the team's 1-bit gate-level 2:1 mux cell via generate.

Verification
REQ-030 Reset release: reset=0 for 2 cycles, then 1 -> out_valid=0, out_data=0; in_ready=0 during reset, 1 one edge after release.
REQ-031 Stream: in_valid=1 with in_data=0x1,0x2,0x3 on consecutive cycles, out_ready=1 -> out_data 0x1,0x2,0x3 one cycle later each, out_valid continuously 1.
REQ-032 Backpressure: send 0xA then 0xB with out_ready=0 -> state FULL, in_ready=0, out_data=0xA held.
- Raise out_ready -> 0xA then 0xB delivered.
- Offered 0xC is accepted only after in_ready returns to 1.
REQ-033 Drain: BUSY holding 0x5, in_valid=0, out_ready=1 -> 0x5 delivered, next cycle out_valid=0.
REQ-034 Mid-operation reset: state FULL with 0xA/0xB, reset=0 one cycle -> out_valid=0, out_data=0; 0xB never appears.
REQ-035 With PIPE_FLUSH_EN: FULL, flush=1 with in_valid=1 and in_data=0xD -> next cycle out_valid=0, in_ready=1; 0xD never delivered.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and state type for the pipeline skid register.
package pipe_pkg;

  localparam int PIPE_WIDTH = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/pipe_mux2_cell.sv
// 1-bit gate-level 2:1 mux cell: y = s ? b : a.
module pipe_mux2_cell (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = (a & ~s) | (b & s);

endmodule

// File: rtl/pipe_skid_mux.sv
// Next-value select for the main register: in_data (sel=0) or skid (sel=1).
module pipe_skid_mux import pipe_pkg::*; #(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] skid,
  input  logic             sel,
  output logic [WIDTH-1:0] main_next
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      pipe_mux2_cell u_cell (
        .a(in_data[gi]),
        .b(skid[gi]),
        .s(sel),
        .y(main_next[gi])
      );
    end
  endgenerate

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer with fully registered in_ready/out_valid/out_data.
// Optional flush port enabled by defining PIPE_FLUSH_EN.
module pipe_skid_reg import pipe_pkg::*; #(
  parameter int WIDTH = PIPE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
`ifdef PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  pipe_state_t      state_reg, state_next;
  logic [WIDTH-1:0] main_reg, skid_reg, main_next;
  logic             in_ready_reg;
  logic             load_main, load_skid;
  logic             in_xfer, out_xfer;

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign in_ready  = in_ready_reg;
  assign in_xfer   = in_valid & in_ready_reg;
  assign out_xfer  = out_valid & out_ready;

  // In FULL the main register refills from skid; otherwise from the input.
  pipe_skid_mux #(.WIDTH(WIDTH)) u_mux (
    .in_data  (in_data),
    .skid     (skid_reg),
    .sel      (state_reg == FULL),
    .main_next(main_next)
  );

  always_comb begin
    state_next = state_reg;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          state_next = BUSY;
          load_main  = 1'b1;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          load_main = 1'b1;
        end else if (in_xfer) begin
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_next = BUSY;
          load_main  = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
`ifdef PIPE_FLUSH_EN
    if (flush) begin
      state_next = EMPTY;
      load_main  = 1'b0;
      load_skid  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != FULL);
      if (load_main) main_reg <= main_next;
      if (load_skid) skid_reg <= in_data;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed + randomized checks of pipe_skid_reg against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         flush = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;

  int passed = 0;
  int total  = 0;

  // Reference model: FIFO of held entries (capacity 2), last shown payload, ready flag.
  logic [W-1:0] q[$];
  logic [W-1:0] m_data  = '0;
  logic         m_ready = 1'b0;
`ifdef PIPE_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
`ifdef PIPE_FLUSH_EN
    .flush    (flush),
`endif
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cycle(input logic rst, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic fl);
    logic in_t, out_t;
    reset = rst; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      m_data  = '0;
      m_ready = 1'b0;
    end else if (fl && FLUSH_ON) begin
      q.delete();
      m_ready = 1'b1;
    end else begin
      in_t  = iv && m_ready;
      out_t = (q.size() > 0) && ordy;
      if (out_t) void'(q.pop_front());
      if (in_t) q.push_back(d);
      if (q.size() > 0) m_data = q[0];
      m_ready = (q.size() < 2);
    end
    #1;
    $display("t=%0t rst=%0b fl=%0b in v/r=%0b/%0b d=%h | out v/r=%0b/%0b d=%h",
             $time, rst, fl, iv, in_ready, d, out_valid, ordy, out_data);
    check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    check("in_ready", {63'd0, in_ready}, {63'd0, m_ready});
    check("out_data", out_data, m_data);
  endtask

  initial begin
    // Reset release
    cycle(0, 1, 64'h99, 1, 0);
    cycle(0, 1, 64'h98, 1, 0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    cycle(1, 0, 0, 1, 0);
    check("release_in_ready", {63'd0, in_ready}, 64'd1);

    // Stream
    cycle(1, 1, 64'h1, 1, 0);
    check("stream1", out_data, 64'h1);
    cycle(1, 1, 64'h2, 1, 0);
    check("stream2", out_data, 64'h2);
    cycle(1, 1, 64'h3, 1, 0);
    check("stream3", out_data, 64'h3);
    check("stream_valid", {63'd0, out_valid}, 64'd1);
    cycle(1, 0, 0, 1, 0);

    // Backpressure
    cycle(1, 1, 64'hA, 0, 0);
    cycle(1, 1, 64'hB, 0, 0);
    check("bp_ready", {63'd0, in_ready}, 64'd0);
    check("bp_hold", out_data, 64'hA);
    cycle(1, 1, 64'hC, 0, 0);
    check("bp_hold2", out_data, 64'hA);
    cycle(1, 1, 64'hC, 1, 0);
    check("bp_deliver_b", out_data, 64'hB);
    cycle(1, 1, 64'hC, 1, 0);
    check("bp_deliver_c", out_data, 64'hC);
    cycle(1, 0, 0, 1, 0);

    // Drain
    cycle(1, 1, 64'h5, 0, 0);
    check("drain_busy", out_data, 64'h5);
    cycle(1, 0, 0, 1, 0);
    check("drain_empty", {63'd0, out_valid}, 64'd0);
    check("drain_retain", out_data, 64'h5);

    // Mid-operation reset
    cycle(1, 1, 64'hA, 0, 0);
    cycle(1, 1, 64'hB, 0, 0);
    cycle(0, 0, 0, 1, 0);
    check("midrst_data", out_data, 64'd0);
    cycle(1, 0, 0, 1, 0);
    check("midrst_valid", {63'd0, out_valid}, 64'd0);

`ifdef PIPE_FLUSH_EN
    // Flush from FULL with a simultaneous offer
    cycle(1, 1, 64'hA, 0, 0);
    cycle(1, 1, 64'hB, 0, 0);
    cycle(1, 1, 64'hD, 0, 1);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_ready", {63'd0, in_ready}, 64'd1);
    cycle(1, 0, 0, 1, 0);
    check("flush_no_d", {63'd0, out_valid}, 64'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(63) != 0),
            ($urandom_range(3) != 0),
            {$urandom(), $urandom()},
            ($urandom_range(2) != 0),
            ($urandom_range(31) == 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
